// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and write-back source encoding.
package core_pkg;
  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  // Index of each producer in request/grant vectors; also the value held in `last`.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LD  = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; `last` remembers the most recent winner.
module rr_arb2
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (&req) gnt[(last == SRC_ALU) ? SRC_LD : SRC_ALU] = 1'b1;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last <= SRC_LD;
    else if (|gnt) last <= gnt[SRC_LD];
  end

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: arbitrates ALU/load results onto the single register
// file write port and tracks pending destinations for RAW/WAW stalls.
module wb_sched
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int RADDR = core_pkg::RADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [RADDR-1:0] iss_rd,
  output logic             iss_ready,
  input  logic [RADDR-1:0] rs1,
  input  logic [RADDR-1:0] rs2,
  output logic             stall,
  input  logic             alu_valid,
  input  logic [RADDR-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [RADDR-1:0] ld_rd,
  input  logic [XLEN-1:0]  ld_data,
  output logic             ld_ready,
  output logic             RegWe,
  output logic [RADDR-1:0] RegWr,
  output logic [XLEN-1:0]  RegWd
);

  localparam int NREG = 1 << RADDR;

  logic [NREG-1:0]            pend, pend_nxt;
  logic [1:0]                 req, gnt;
  logic [1:0][RADDR-1:0]      src_rd;
  logic [1:0][XLEN-1:0]       src_data;
  logic                       sel, any_gnt;

  // rst_n is an active-high reset on this block.
  assign req[SRC_ALU]      = alu_valid;
  assign req[SRC_LD]       = ld_valid;
  assign src_rd[SRC_ALU]   = alu_rd;
  assign src_rd[SRC_LD]    = ld_rd;
  assign src_data[SRC_ALU] = alu_data;
  assign src_data[SRC_LD]  = ld_data;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst_n),
    .req (req),
    .gnt (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign ld_ready  = gnt[SRC_LD];
  assign any_gnt   = |gnt;
  assign sel       = gnt[SRC_LD];

  always_comb begin
    stall = (pend[rs1] && (rs1 != '0)) ||
            (pend[rs2] && (rs2 != '0)) ||
            (iss_valid && pend[iss_rd] && (iss_rd != '0));
  end

  assign iss_ready = iss_valid && !stall && !rst_n;

  // Set is applied after clear so a same-edge issue to a just-written rd survives.
  always_comb begin
    pend_nxt = pend;
    if (RegWe) pend_nxt[RegWr] = 1'b0;
    if (iss_ready && (iss_rd != '0)) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pend  <= '0;
      RegWe <= 1'b0;
      RegWr <= '0;
      RegWd <= '0;
    end else begin
      pend  <= pend_nxt;
      RegWe <= any_gnt && (src_rd[sel] != '0);
      if (any_gnt) begin
        RegWr <= src_rd[sel];
        RegWd <= src_data[sel];
      end
    end
  end

endmodule
